// File: rtl/shift_sched_pkg.sv
// ---------------------------------------------------------------------------
// shift_sched_pkg
//   Shared types and constants for the shift_scheduler block.
//   - state_t     : scheduler FSM states
//   - BYTE_W      : width of one requester byte
//   - NBITS       : bits shifted per job (BYTE_W, plus one parity bit when
//                   SHIFT_SCHED_PARITY_EN is defined)
//   - clog2_min1  : $clog2 clamped to a minimum of 1 (index widths)
// Configuration macro: SHIFT_SCHED_PARITY_EN
// ---------------------------------------------------------------------------
package shift_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      SHIFT,
      DRAIN,
      DONE
   } state_t;

   localparam int BYTE_W = 8;

`ifdef SHIFT_SCHED_PARITY_EN
   localparam int NBITS = BYTE_W + 1;
`else
   localparam int NBITS = BYTE_W;
`endif

   function automatic int clog2_min1(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shift_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first asserted request at or above
//   ptr, wrapping modulo NUM_REQ.
// Ports
//   req      in   NUM_REQ  request vector
//   ptr      in   IDW      highest-priority index for this pick
//   win      out  NUM_REQ  one-hot winner (all zero when no request)
//   win_idx  out  IDW      index of the winner (0 when no request)
//   any      out  1        at least one request asserted
// ---------------------------------------------------------------------------
module rr_arbiter
   import shift_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDW     = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] win,
   output logic [IDW-1:0]     win_idx,
   output logic               any
);

   logic           found;
   logic [IDW:0]   sum;
   logic [IDW-1:0] idx;

   // Walk the requesters starting at ptr; ptr < NUM_REQ and k < NUM_REQ,
   // so one conditional subtraction is enough to wrap.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NUM_REQ)) begin
            sum = sum - (IDW+1)'(NUM_REQ);
         end
         idx = sum[IDW-1:0];
         if (!found && req[idx]) begin
            found   = 1'b1;
            win_idx = idx;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_win
         assign win[gi] = found && (win_idx == IDW'(gi));
      end
   endgenerate

   assign any = found;

endmodule

// File: rtl/shift_scheduler.sv
// ---------------------------------------------------------------------------
// shift_scheduler
//   Round-robin owner of one downstream serial-in shift register. A granted
//   requester's byte is shifted out MSB first, one bit per cycle, then the
//   scheduler waits DRAIN_CYC cycles for the register's input pipeline and
//   pulses done with the owner's id. Every output is a flop.
// Parameters
//   NUM_REQ    number of requesters (2..8)
//   DRAIN_CYC  cycles from last shift_enable until the byte is valid (>=1)
// Ports
//   clk           in   1            rising-edge clock
//   reset         in   1            asynchronous, active-low
//   req           in   NUM_REQ      level requests, held until gnt
//   req_data      in   8*NUM_REQ    byte i at [8*i+7:8*i]
//   gnt           out  NUM_REQ      one-hot one-cycle grant pulse
//   shift_data    out  1            serial bit to the shift register
//   shift_enable  out  1            shift strobe to the shift register
//   busy          out  1            high from gnt cycle through done cycle
//   done          out  1            one-cycle pulse, byte is in the register
//   done_id       out  IDW          owner of the finished job
// Configuration macro: SHIFT_SCHED_PARITY_EN (adds a 9th, even-parity bit)
// ---------------------------------------------------------------------------
module shift_scheduler
   import shift_sched_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DRAIN_CYC = 2,
   localparam int IDW      = clog2_min1(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [BYTE_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     shift_data,
   output logic                     shift_enable,
   output logic                     busy,
   output logic                     done,
   output logic [IDW-1:0]           done_id
);

   localparam int CNT_W  = $clog2(NBITS + 1);
   localparam int DCNT_W = clog2_min1(DRAIN_CYC + 1);
   localparam int BIT_W  = $clog2(BYTE_W);

   state_t               state_reg, state_next;
   logic [IDW-1:0]       ptr_reg, ptr_next;
   logic [IDW-1:0]       owner_reg, owner_next;
   logic [NUM_REQ-1:0]   owner_oh_reg, owner_oh_next;
   logic [BYTE_W-1:0]    byte_reg, byte_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic [DCNT_W-1:0]    dcnt_reg, dcnt_next;

   logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
   logic                 shift_data_reg, shift_data_next;
   logic                 shift_enable_reg, shift_enable_next;
   logic                 busy_reg, busy_next;
   logic                 done_reg, done_next;
   logic [IDW-1:0]       done_id_reg, done_id_next;

   logic [NUM_REQ-1:0]   arb_win;
   logic [IDW-1:0]       arb_idx;
   logic                 arb_any;
   logic [BYTE_W-1:0]    req_bytes [NUM_REQ];
   logic [BIT_W-1:0]     bit_idx;
   logic                 tx_bit;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
         assign req_bytes[gi] = req_data[BYTE_W*gi +: BYTE_W];
      end
   endgenerate

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_arb (
      .req     (req),
      .ptr     (ptr_reg),
      .win     (arb_win),
      .win_idx (arb_idx),
      .any     (arb_any)
   );

   // MSB first: shift cycle cnt carries byte[7-cnt]
   assign bit_idx = BIT_W'(CNT_W'(BYTE_W - 1) - cnt_reg);

`ifdef SHIFT_SCHED_PARITY_EN
   assign tx_bit = (cnt_reg == CNT_W'(BYTE_W)) ? ^byte_reg : byte_reg[bit_idx];
`else
   assign tx_bit = byte_reg[bit_idx];
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg        <= IDLE;
         ptr_reg          <= '0;
         owner_reg        <= '0;
         owner_oh_reg     <= '0;
         byte_reg         <= '0;
         cnt_reg          <= '0;
         dcnt_reg         <= '0;
         gnt_reg          <= '0;
         shift_data_reg   <= 1'b0;
         shift_enable_reg <= 1'b0;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
         done_id_reg      <= '0;
      end else begin
         state_reg        <= state_next;
         ptr_reg          <= ptr_next;
         owner_reg        <= owner_next;
         owner_oh_reg     <= owner_oh_next;
         byte_reg         <= byte_next;
         cnt_reg          <= cnt_next;
         dcnt_reg         <= dcnt_next;
         gnt_reg          <= gnt_next;
         shift_data_reg   <= shift_data_next;
         shift_enable_reg <= shift_enable_next;
         busy_reg         <= busy_next;
         done_reg         <= done_next;
         done_id_reg      <= done_id_next;
      end
   end

   // Output flops are loaded from the current state, so each output appears
   // one cycle after the FSM enters the state that produces it.
   always_comb begin
      state_next        = state_reg;
      ptr_next          = ptr_reg;
      owner_next        = owner_reg;
      owner_oh_next     = owner_oh_reg;
      byte_next         = byte_reg;
      cnt_next          = cnt_reg;
      dcnt_next         = dcnt_reg;
      gnt_next          = '0;
      shift_data_next   = 1'b0;
      shift_enable_next = 1'b0;
      busy_next         = (state_reg != IDLE);
      done_next         = 1'b0;
      done_id_next      = '0;

      case (state_reg)
         IDLE: begin
            if (arb_any) begin
               state_next    = GRANT;
               owner_next    = arb_idx;
               owner_oh_next = arb_win;
               ptr_next      = (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end
         end
         GRANT: begin
            // byte is taken here, before the requester can observe gnt
            gnt_next   = owner_oh_reg;
            byte_next  = req_bytes[owner_reg];
            cnt_next   = '0;
            state_next = SHIFT;
         end
         SHIFT: begin
            shift_enable_next = 1'b1;
            shift_data_next   = tx_bit;
            if (cnt_reg == CNT_W'(NBITS - 1)) begin
               cnt_next   = '0;
               dcnt_next  = '0;
               state_next = DRAIN;
            end else if (cnt_reg != CNT_W'(NBITS)) begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DRAIN: begin
            if (dcnt_reg == DCNT_W'(DRAIN_CYC - 1)) begin
               dcnt_next  = '0;
               state_next = DONE;
            end else begin
               dcnt_next = dcnt_reg + 1'b1;
            end
         end
         DONE: begin
            done_next    = 1'b1;
            done_id_next = owner_reg;
            state_next   = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign gnt          = gnt_reg;
   assign shift_data   = shift_data_reg;
   assign shift_enable = shift_enable_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign done_id      = done_id_reg;

endmodule

// File: tb/tb_shift_scheduler.sv
// ---------------------------------------------------------------------------
// tb_shift_scheduler
//   Directed bench for shift_scheduler (NUM_REQ=4, DRAIN_CYC=2). A model of
//   the downstream register (2-stage input pipeline + 8-bit shifter) follows
//   shift_data/shift_enable. Honours SHIFT_SCHED_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_shift_scheduler;

`ifdef SHIFT_SCHED_PARITY_EN
   localparam int NB    = 9;
   localparam int LAT   = 12;
   localparam logic [7:0] SR_FF = 8'hFE;
`else
   localparam int NB    = 8;
   localparam int LAT   = 11;
   localparam logic [7:0] SR_FF = 8'hFF;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req = 4'b0;
   logic [31:0] req_data = 32'h0;
   logic [3:0]  gnt;
   logic        shift_data;
   logic        shift_enable;
   logic        busy;
   logic        done;
   logic [1:0]  done_id;

   int checks = 0;
   int failures = 0;

   shift_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_data     (req_data),
      .gnt          (gnt),
      .shift_data   (shift_data),
      .shift_enable (shift_enable),
      .busy         (busy),
      .done         (done),
      .done_id      (done_id)
   );

   always #5 clk = ~clk;

   // downstream shift register model
   logic       p1_d, p1_e, p2_d, p2_e;
   logic [7:0] sr;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         p1_d <= 1'b0; p1_e <= 1'b0; p2_d <= 1'b0; p2_e <= 1'b0; sr <= 8'h00;
      end else begin
         if (p2_e) sr <= {sr[6:0], p2_d};
         p2_d <= p1_d;
         p2_e <= p1_e;
         p1_d <= shift_data;
         p1_e <= shift_enable;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: wait bound expired, got no event, required one", name);
   endtask

   task automatic wait_gnt(output bit got);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gnt != 4'b0) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(output bit got, output int n, output int nb, output logic [8:0] bits);
      got = 1'b0; n = 0; nb = 0; bits = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n++;
         if (shift_enable) begin
            bits = {bits[7:0], shift_data};
            nb++;
         end
         if (done) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   typedef struct {
      int         idx;
      logic [7:0] data;
      logic [3:0] exp_gnt;
      logic [1:0] exp_id;
      logic [7:0] exp_sr;
      logic [8:0] exp_bits;
   } vec_t;

   vec_t vecs [5];

   task automatic run_job(input vec_t v);
      bit got;
      int n, nb;
      logic [8:0] bits;
      req_data[v.idx*8 +: 8] = v.data;
      req = 4'b0001 << v.idx;
      wait_gnt(got);
      if (!got) begin
         bound_fail("job_gnt");
         req = 4'b0;
         return;
      end
      check("job_gnt", 32'(gnt), 32'(v.exp_gnt));
      check("job_busy_at_gnt", 32'(busy), 32'd1);
      req = 4'b0;
      wait_done(got, n, nb, bits);
      if (!got) begin
         bound_fail("job_done");
         return;
      end
      check("job_latency", n, LAT);
      check("job_done_id", 32'(done_id), 32'(v.exp_id));
      check("job_shift_count", nb, NB);
      check("job_shift_bits", 32'(bits), 32'(v.exp_bits));
      check("job_sr_model", 32'(sr), 32'(v.exp_sr));
      $display("job req=%0d byte=%02h done_id=%0d latency=%0d shifts=%0d sr=%02h",
               v.idx, v.data, done_id, n, nb, sr);
      @(negedge clk);
      check("job_idle_after_done", 32'({busy, done}), 32'd0);
   endtask

   initial begin
      bit         got;
      int         n, nb, t, last_done, k, ndone, nbusy, id_seen;
      bit         saw2;
      logic [8:0] bits;

`ifdef SHIFT_SCHED_PARITY_EN
      vecs[0] = '{1, 8'hA5, 4'b0010, 2'd1, 8'h4A, 9'h14A};
      vecs[1] = '{3, 8'h00, 4'b1000, 2'd3, 8'h00, 9'h000};
      vecs[2] = '{3, 8'hFF, 4'b1000, 2'd3, 8'hFE, 9'h1FE};
      vecs[3] = '{0, 8'h3C, 4'b0001, 2'd0, 8'h78, 9'h078};
      vecs[4] = '{2, 8'h07, 4'b0100, 2'd2, 8'h0F, 9'h00F};
`else
      vecs[0] = '{1, 8'hA5, 4'b0010, 2'd1, 8'hA5, 9'h0A5};
      vecs[1] = '{3, 8'h00, 4'b1000, 2'd3, 8'h00, 9'h000};
      vecs[2] = '{3, 8'hFF, 4'b1000, 2'd3, 8'hFF, 9'h0FF};
      vecs[3] = '{0, 8'h3C, 4'b0001, 2'd0, 8'h3C, 9'h03C};
      vecs[4] = '{2, 8'h07, 4'b0100, 2'd2, 8'h07, 9'h007};
`endif

      // reset state
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({gnt, shift_data, shift_enable, busy, done, done_id}), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("idle_after_reset", 32'({gnt, shift_data, shift_enable, busy, done, done_id}), 32'd0);

      // single jobs from the table
      for (int i = 0; i < 5; i++) begin
         run_job(vecs[i]);
      end

      // back-to-back from req[3]: 8'h00 then 8'hFF
      req_data[31:24] = 8'h00;
      req = 4'b1000;
      wait_gnt(got);
      if (!got) bound_fail("b2b_gnt1");
      check("b2b_gnt1", 32'(gnt), 32'h8);
      req_data[31:24] = 8'hFF;
      wait_done(got, n, nb, bits);
      if (!got) bound_fail("b2b_done1");
      check("b2b_sr1", 32'(sr), 32'h00);
      $display("b2b job1 done_id=%0d sr=%02h", done_id, sr);
      @(negedge clk);
      check("b2b_gap", 32'({busy, gnt}), 32'd0);
      @(negedge clk);
      check("b2b_regrant", 32'({busy, gnt}), 32'h18);
      req = 4'b0;
      wait_done(got, n, nb, bits);
      if (!got) bound_fail("b2b_done2");
      check("b2b_sr2", 32'(sr), 32'(SR_FF));
      check("b2b_id2", 32'(done_id), 32'd3);
      $display("b2b job2 done_id=%0d sr=%02h", done_id, sr);
      @(negedge clk);

      // req[2] pulsed while req[0]'s job is shifting
      req_data[7:0] = 8'h5A;
      req = 4'b0001;
      wait_gnt(got);
      if (!got) bound_fail("drop_gnt");
      check("drop_gnt0", 32'(gnt), 32'h1);
      req = 4'b0;
      saw2 = 1'b0; ndone = 0; id_seen = 0;
      for (int i = 1; i <= 35; i++) begin
         @(negedge clk);
         if (gnt[2]) saw2 = 1'b1;
         if (done) begin
            ndone++;
            id_seen = int'(done_id);
         end
         if (i == 3) req = 4'b0100;
         if (i == 4) req = 4'b0000;
      end
      check("drop_no_gnt2", 32'(saw2), 32'd0);
      check("drop_done_count", ndone, 1);
      check("drop_done_id", id_seen, 0);
      $display("drop job dones=%0d done_id=%0d gnt2_seen=%0d", ndone, id_seen, saw2);

      // reset after the 3rd shift_enable
      req_data[15:8] = 8'hC3;
      req = 4'b0010;
      wait_gnt(got);
      if (!got) bound_fail("rst_gnt");
      req = 4'b0;
      n = 0;
      for (int i = 0; i < 10 && n < 3; i++) begin
         @(negedge clk);
         if (shift_enable) n++;
      end
      if (n < 3) bound_fail("rst_shift3");
      check("rst_busy_before", 32'(busy), 32'd1);
      #2 reset = 1'b0;
      #1 check("rst_async_outputs",
               32'({gnt, shift_data, shift_enable, busy, done, done_id}), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      ndone = 0; nbusy = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) ndone++;
         if (busy || gnt != 4'b0) nbusy++;
      end
      check("rst_no_done", ndone, 0);
      check("rst_stays_idle", nbusy, 0);
      $display("reset mid-job dones=%0d busy_cycles=%0d", ndone, nbusy);

      // all four requesting from reset release
      reset = 1'b0;
      req_data = 32'h44332211;
      req = 4'b1111;
      @(negedge clk);
      reset = 1'b1;
      t = 0; last_done = -100; k = 0;
      for (int i = 0; i < 150 && k < 5; i++) begin
         @(negedge clk);
         t++;
         if (done) last_done = t;
         if (gnt != 4'b0) begin
            check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1) << (k % 4));
            if (k > 0) check($sformatf("rr_gap%0d", k), t - last_done, 2);
            $display("rr grant %0d gnt=%b cycle=%0d", k, gnt, t);
            k++;
         end
      end
      if (k < 5) bound_fail("rr_grants");
      req = 4'b0;
      got = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!busy) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) bound_fail("rr_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
